seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised serial pattern detector, the successor to the fixed single-pattern detector.
- Pattern length is set by parameter; the pattern itself is loadable at run time.
- Overlapping/non-overlapping mode is selectable at run time.
- Input bits are qualified by a valid strobe; a saturating match counter is provided.
- Sits between a serial bit source and control/status logic that consumes a one-cycle match pulse and a detection count.

Parameters:
- N, 4, pattern length in bits (legal 2..16).
- PAT_RST, 4'b1011, pattern register value after reset (N bits wide).
- CNT_W, 8, match counter width (legal 1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- seq  input  1  serial data bit; sampled only when seq_valid=1.
- seq_valid  input  1  qualifies seq for the current cycle.
- pat_in  input  N  new pattern; pat_in[N-1] is the first bit expected.
- pat_load  input  1  load pat_in into the pattern register this cycle.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  synchronous clear of match_cnt.
- dout  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset (async, rst=1):
  - pattern register <= PAT_RST; history register hist[N-1:0] <= 0; fill counter <= 0.
  - dout <= 0; match_cnt <= 0.
  - Outputs are forced immediately, not at the next clock edge.
- State: pattern register, hist (last N accepted bits, newest in bit 0), fill counter 0..N (number of valid bits held since last clear, saturates at N).
- Accept edge (seq_valid=1, pat_load=0):
  - hist_next = {hist[N-2:0], seq}.
  - fill_next = min(fill+1, N).
  - match = (fill_next==N) && (hist_next==pattern).
- Latency: dout=1 in the cycle immediately after the edge that accepts the final pattern bit; the pulse is exactly one cycle wide.
- Idle cycle (seq_valid=0, pat_load=0): hist and fill hold; dout <= 0 next cycle. Gaps between valid bits do not break a partial match.
- Overlap handling on match, with overlap sampled at the matching edge:
  - overlap=1: hist and fill keep their updated values, so a suffix can start the next match.
  - overlap=0: fill <= 0 and hist <= 0; the next match needs N fresh bits.
- pat_load=1 (priority over seq_valid):
  - pattern <= pat_in; fill <= 0; hist <= 0.
  - The seq bit in that cycle is discarded; dout <= 0 next cycle.
- match_cnt:
  - Increments by 1 on each match edge; saturates at all-ones with no wrap.
  - cnt_clr=1 with no match: match_cnt <= 0.
  - cnt_clr=1 with a simultaneous match: match_cnt <= 1.
  - cnt_clr has no effect on detection state.
- A mismatch with fill==N requires no action; hist keeps shifting (sliding window), so no explicit FSM fallback table is needed.
- Reset asserted mid-sequence: the partial match is lost; after release, detection restarts from fill=0 with pattern=PAT_RST (any loaded pattern is lost).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- N=4, after reset, overlap=1, seq_valid=1, bits 1,0,1,1 -> dout=1 for one cycle after the 4th-bit edge, match_cnt=1, dout=0 the cycle after.
- overlap=1, bits 1,0,1,1,0,1,1 -> dout pulses after bit 4 and bit 7, match_cnt=2. Same stream with overlap=0 -> single pulse after bit 4, match_cnt=1.
- Bits 1,0,1,1 with seq_valid low for 3 cycles between bits 2 and 3 -> exactly one pulse, one cycle after the edge accepting the final 1; no pulses during the gaps.
- Bits 1,0 accepted, then pat_load=1 with pat_in=4'b0110 while seq=1, seq_valid=1 -> that bit is ignored. Then bits 0,1,1,0 -> one pulse after the 4th bit. Stream 1,0,1,1 afterwards -> no pulse.
- CNT_W=2: five non-overlapping matches -> match_cnt reads 1,2,3,3,3. Then cnt_clr coincident with the next match -> match_cnt=1.
- Accept bits 1,0,1, then assert rst asynchronously between edges -> dout and match_cnt go to 0 immediately. After release, bit 1 alone -> no pulse; the full 1,0,1,1 is required to match.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time loadable serial pattern detector with overlap control and saturating match counter.
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   seq        serial data bit, used only when seq_valid=1
//   seq_valid  qualifies seq for the current cycle
//   pat_in     new pattern, pat_in[N-1] is the first bit expected
//   pat_load   loads pat_in and restarts detection (wins over seq_valid)
//   overlap    1 = a match suffix may start the next match, 0 = restart after a match
//   cnt_clr    synchronous clear of match_cnt (a coincident match leaves it at 1)
//   dout       registered one-cycle match pulse
//   match_cnt  saturating count of matches
module seq_detector_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PAT_RST = N'(4'b1011),
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seq,
    input  logic             seq_valid,
    input  logic [N-1:0]     pat_in,
    input  logic             pat_load,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);
    localparam int FW = $clog2(N + 1);

    logic [N-1:0]     r_pat;
    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_dout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic [N-1:0]     w_hist_shift;
    logic [FW-1:0]    w_fill_inc;
    logic             w_match;
    logic             w_restart;
    logic [N-1:0]     w_pat_nxt;
    logic [N-1:0]     w_hist_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // The window slides on every accepted bit; the fill count only gates
    // matching until N bits have been seen since the last restart.
    always_comb begin
        w_accept     = seq_valid & ~pat_load;
        w_hist_shift = {r_hist[N-2:0], seq};
        w_fill_inc   = (r_fill == FW'(N)) ? r_fill : r_fill + 1'b1;
        w_match      = w_accept && (w_fill_inc == FW'(N)) && (w_hist_shift == r_pat);
        // A pattern load, or a match in non-overlapping mode, empties the window.
        w_restart    = pat_load | (w_match & ~overlap);
        w_pat_nxt    = pat_load ? pat_in : r_pat;
        w_hist_nxt   = w_restart ? '0 : w_accept ? w_hist_shift : r_hist;
        w_fill_nxt   = w_restart ? '0 : w_accept ? w_fill_inc : r_fill;
        w_cnt_nxt    = cnt_clr ? (w_match ? CNT_W'(1) : '0) :
                       (w_match && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pat  <= PAT_RST;
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
            r_dout <= w_match;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign dout      = r_dout;
    assign match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: scoreboard bench for seq_detector_param with directed and random stimulus.
module tb_seq_detector_param;
    localparam int N     = 4;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam logic [N-1:0] PAT_RST = 4'b1011;

    typedef struct {
        bit dout;
        int cnt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seq = 1'b0;
    logic             seq_valid = 1'b0;
    logic [N-1:0]     pat_in = '0;
    logic             pat_load = 1'b0;
    logic             overlap = 1'b1;
    logic             cnt_clr = 1'b0;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;

    exp_t         exp_q[$];
    bit           win[$];
    logic [N-1:0] m_pat = PAT_RST;
    int           m_cnt = 0;
    int           n_chk = 0;
    int           n_pass = 0;

    seq_detector_param #(.N(N), .PAT_RST(PAT_RST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid),
        .pat_in(pat_in), .pat_load(pat_load), .overlap(overlap),
        .cnt_clr(cnt_clr), .dout(dout), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    endtask

    // Reference: keep the accepted bits since the last restart, oldest first;
    // a match is the last N of them reading as the pattern, MSB first.
    task automatic cyc(input bit s, input bit v, input bit l, input logic [N-1:0] p,
                       input bit ov, input bit c);
        exp_t e;
        bit m = 0;
        logic [N-1:0] w;
        seq = s; seq_valid = v; pat_load = l; pat_in = p; overlap = ov; cnt_clr = c;
        if (l) begin
            m_pat = p;
            win.delete();
        end else if (v) begin
            win.push_back(s);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                for (int i = 0; i < N; i++) w[N-1-i] = win[i];
                m = (w == m_pat);
            end
            if (m && !ov) win.delete();
        end
        if (c) m_cnt = m ? 1 : 0;
        else if (m && m_cnt < CMAX) m_cnt++;
        e.dout = m;
        e.cnt  = m_cnt;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic feed(input int len, input logic [15:0] b, input bit ov);
        for (int i = len - 1; i >= 0; i--) cyc(b[i], 1'b1, 1'b0, '0, ov, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic load(input logic [N-1:0] p);
        cyc(1'b0, 1'b0, 1'b1, p, 1'b1, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("dout", int'(dout), int'(e.dout));
                chk("match_cnt", int'(match_cnt), e.cnt);
            end
        end
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        chk("reset_dout", int'(dout), 0);
        chk("reset_cnt", int'(match_cnt), 0);
        rst = 1'b0;
        // single match, then overlap vs non-overlap
        feed(4, 16'b1011, 1'b1);
        idle(2);
        load(4'b1011);
        feed(7, 16'b1011011, 1'b1);
        idle(1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        load(4'b1011);
        feed(7, 16'b1011011, 1'b0);
        idle(1);
        // gaps inside a partial match
        load(4'b1011);
        feed(2, 16'b10, 1'b1);
        idle(3);
        feed(2, 16'b11, 1'b1);
        idle(2);
        // pattern load discards the coincident bit
        load(4'b1011);
        feed(2, 16'b10, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
        feed(4, 16'b0110, 1'b1);
        idle(1);
        feed(4, 16'b1011, 1'b1);
        idle(1);
        // saturation and clear coincident with a match
        load(4'b1011);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) feed(4, 16'b1011, 1'b0);
        feed(3, 16'b101, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        idle(1);
        // asynchronous reset mid-sequence restores PAT_RST
        load(4'b0110);
        feed(4, 16'b0110, 1'b1);
        feed(3, 16'b101, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_dout", int'(dout), 0);
        chk("async_rst_cnt", int'(match_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        m_pat = PAT_RST;
        win.delete();
        m_cnt = 0;
        cyc(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        feed(4, 16'b1011, 1'b1);
        idle(1);
        // random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [N-1:0] p;
            p = N'($urandom_range(0, (1 << N) - 1));
            cyc(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 40) == 0, p, bit'($urandom_range(0, 1)),
                $urandom_range(0, 25) == 0);
        end
        idle(2);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
